fp16_mul_sched: RTL and testbench

FP16_MUL_SCHED -- requirements
Module: fp16_mul_sched

---
 rtl/fp16_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/fp16_mul_sched.sv | 127 ++++++++++++
 tb/tb_fp16_mul_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// FP16 (1/5/10) field widths, exponent bias, zero encoding and the truncating
// multiply shared by the scheduler. No inf/NaN/denormal handling; -0 is nonzero.
package fp16_pkg;

    localparam int unsigned FP16_W = 16;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned MAN_W  = 10;

    localparam logic [EXP_W-1:0]  EXP_BIAS  = 5'd15;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

    // Truncating FP16 product; exponent wraps modulo 32.
    function automatic logic [FP16_W-1:0] fp16Mul(input logic [FP16_W-1:0] a,
                                                  input logic [FP16_W-1:0] b);
        logic [2*MAN_W+1:0] prod;
        logic [MAN_W-1:0]   mant;
        logic [EXP_W-1:0]   expo;
        logic               sign;
        prod = {{(MAN_W+1){1'b0}}, 1'b1, a[MAN_W-1:0]} *
               {{(MAN_W+1){1'b0}}, 1'b1, b[MAN_W-1:0]};
        sign = a[FP16_W-1] ^ b[FP16_W-1];
        expo = a[FP16_W-2:MAN_W] + b[FP16_W-2:MAN_W] - EXP_BIAS
               + {{(EXP_W-1){1'b0}}, prod[2*MAN_W+1]};
        mant = prod[2*MAN_W+1] ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];
        if (a == FP16_ZERO || b == FP16_ZERO)
            return FP16_ZERO;
        return {sign, expo, mant};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            valid
);

    // Scan upward from ptr, taking the first requester found.
    always_comb begin : pick
        int unsigned j;
        logic [IDW-1:0] jIdx;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        jIdx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NREQ)
                j = j - NREQ;
            jIdx = IDW'(j);
            if (!valid && req[jIdx]) begin
                valid       = 1'b1;
                grant[jIdx] = 1'b1;
                idx         = jIdx;
            end
        end
    end

endmodule

// File: rtl/fp16_mul_sched.sv
// Shares one FP16 multiplier among NREQ requesters with round-robin arbitration
// and a stallable output stage. Define FP16_MUL_SCHED_IN_REG_EN to add an operand
// register ahead of the multiplier (latency 2 instead of 1, still full rate).
module fp16_mul_sched
    import fp16_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    output logic [FP16_W-1:0]    res_data,
    output logic [IDW-1:0]       res_id,
    input  logic                 res_ready
);

    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    grantIdx;
    logic [NREQ-1:0]   grant;
    logic              anyGrant;
    logic              outCanLoad;
    logic              firstReady;
    logic              accept;
    logic              loadValid;
    logic [IDW-1:0]    loadId;
    logic [FP16_W-1:0] selA;
    logic [FP16_W-1:0] selB;
    logic [FP16_W-1:0] mulA;
    logic [FP16_W-1:0] mulB;
    logic [FP16_W-1:0] product;

    rr_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) uArb (
        .req  (req_valid),
        .ptr  (ptr),
        .grant(grant),
        .idx  (grantIdx),
        .valid(anyGrant)
    );

    // Handshake and winner operand mux; ready is forced low while in reset.
    always_comb begin
        outCanLoad = !res_valid || res_ready;
        accept     = anyGrant && firstReady && rst_n;
        req_ready  = (firstReady && rst_n) ? grant : '0;
        selA       = req_a[{grantIdx, 4'b0000} +: 16];
        selB       = req_b[{grantIdx, 4'b0000} +: 16];
    end

`ifdef FP16_MUL_SCHED_IN_REG_EN
    logic              inValid;
    logic [FP16_W-1:0] inA;
    logic [FP16_W-1:0] inB;
    logic [IDW-1:0]    inId;

    // Operand stage accepts when empty or when its content moves to the output stage.
    always_comb begin
        firstReady = !inValid || outCanLoad;
        mulA       = inA;
        mulB       = inB;
        loadValid  = inValid;
        loadId     = inId;
    end

    // Operand register ahead of the multiplier.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inValid <= 1'b0;
            inA     <= '0;
            inB     <= '0;
            inId    <= '0;
        end else if (firstReady) begin
            inValid <= accept;
            if (accept) begin
                inA  <= selA;
                inB  <= selB;
                inId <= grantIdx;
            end
        end
    end
`else
    // Multiplier fed straight from the arbiter mux.
    always_comb begin
        firstReady = outCanLoad;
        mulA       = selA;
        mulB       = selB;
        loadValid  = accept;
        loadId     = grantIdx;
    end
`endif

    // Single shared multiplier.
    always_comb begin
        product = fp16Mul(mulA, mulB);
    end

    // Round-robin pointer moves past the winner on each acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= '0;
        else if (accept)
            ptr <= (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
    end

    // Output stage: holds data/id while stalled, loads when empty or draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
        end else if (outCanLoad) begin
            res_valid <= loadValid;
            if (loadValid) begin
                res_data <= product;
                res_id   <= loadId;
            end
        end
    end

endmodule

// File: tb/tb_fp16_mul_sched.sv
// Scoreboard bench for fp16_mul_sched (NREQ=4). Honors FP16_MUL_SCHED_IN_REG_EN
// for the expected latency of the directed cases.
module tb_fp16_mul_sched;

`ifdef FP16_MUL_SCHED_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  reqValid;
    logic [63:0] reqA;
    logic [63:0] reqB;
    logic [3:0]  reqReady;
    logic        resValid;
    logic [15:0] resData;
    logic [1:0]  resId;
    logic        resReady;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  id;
    } exp_t;

    exp_t        sbQ[$];
    int unsigned mPtr;
    int          tests;
    int          fails;

    fp16_mul_sched #(
        .NREQ(4),
        .IDW (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(reqValid),
        .req_a    (reqA),
        .req_b    (reqB),
        .req_ready(reqReady),
        .res_valid(resValid),
        .res_data (resData),
        .res_id   (resId),
        .res_ready(resReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product from the arithmetic rules, using plain integers.
    function automatic logic [15:0] modelMul(input logic [15:0] a, input logic [15:0] b);
        int unsigned ma, mb, p, mant, e;
        logic s;
        if (a == 16'h0000 || b == 16'h0000)
            return 16'h0000;
        s  = a[15] ^ b[15];
        ma = 1024 + a[9:0];
        mb = 1024 + b[9:0];
        p  = ma * mb;
        e  = a[14:10] + b[14:10] + 32 - 15;
        if (p >= (1 << 21)) begin
            mant = (p >> 11) % 1024;
            e    = e + 1;
        end else begin
            mant = (p >> 10) % 1024;
        end
        e = e % 32;
        return {s, 5'(e), 10'(mant)};
    endfunction

    function automatic int unsigned rrWinner(input logic [3:0] v, input int unsigned p);
        for (int unsigned k = 0; k < 4; k++)
            if (v[(p + k) % 4])
                return (p + k) % 4;
        return 0;
    endfunction

    function automatic logic [15:0] randOp();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'h8000;
        return 16'($urandom);
    endfunction

    // Monitor: predict grants, push accepted work, compare every presented result.
    always @(negedge clk) begin : monitor
        int unsigned w;
        exp_t e;
        if (!rst_n) begin
            sbQ.delete();
            mPtr = 0;
            check("reset_req_ready", 32'(reqReady), 0);
        end else begin
            if (resValid) begin
                if (sbQ.size() == 0) begin
                    check("spurious_res_valid", 32'(resValid), 0);
                end else begin
                    check("res_data", 32'(resData), 32'(sbQ[0].data));
                    check("res_id", 32'(resId), 32'(sbQ[0].id));
                    if (resReady)
                        void'(sbQ.pop_front());
                end
            end
            w = rrWinner(reqValid, mPtr);
            if (reqReady != 4'b0000)
                check("grant_onehot", 32'(reqReady), 32'(4'b0001 << w));
`ifndef FP16_MUL_SCHED_IN_REG_EN
            if ((!resValid || resReady) && reqValid != 4'b0000)
                check("ready_when_free", 32'(reqReady != 4'b0000), 1);
`endif
            if ((reqValid & reqReady) != 4'b0000) begin
                e.data = modelMul(reqA[16*w +: 16], reqB[16*w +: 16]);
                e.id   = 2'(w);
                sbQ.push_back(e);
                mPtr = (w + 1) % 4;
            end
        end
    end

    task automatic pulseReset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_ready_zero", 32'(reqReady), 0);
        @(posedge clk);
        #1;
        check("rst_res_valid", 32'(resValid), 0);
        check("rst_res_data", 32'(resData), 0);
        check("rst_res_id", 32'(resId), 0);
        rst_n = 1'b1;
    endtask

    task automatic issue(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] expD);
        @(posedge clk);
        #1;
        reqValid = 4'b0001 << idx;
        reqA[16*idx +: 16] = a;
        reqB[16*idx +: 16] = b;
        @(negedge clk);
        check("dir_ready", 32'(reqReady), 32'(4'b0001 << idx));
        @(posedge clk);
        #1 reqValid = 4'b0000;
        for (int k = 1; k < LAT; k++) begin
            @(posedge clk);
            #1;
        end
        check("dir_valid", 32'(resValid), 1);
        check("dir_data", 32'(resData), 32'(expD));
        check("dir_id", 32'(resId), idx);
    endtask

    initial begin : main
        logic [3:0] acc;
        tests    = 0;
        fails    = 0;
        mPtr     = 0;
        rst_n    = 1'b0;
        reqValid = 4'b0000;
        reqA     = '0;
        reqB     = '0;
        resReady = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("init_res_valid", 32'(resValid), 0);
        check("init_res_data", 32'(resData), 0);
        check("init_res_id", 32'(resId), 0);
        rst_n = 1'b1;

        issue(0, 16'h3C00, 16'h4000, 16'h4000);
        issue(2, 16'h3E00, 16'h3E00, 16'h4080);
        issue(2, 16'h0000, 16'h4500, 16'h0000);
        issue(2, 16'hBC00, 16'h4000, 16'hC000);

        // All requesters continuously valid from reset: strict rotation.
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            reqA[16*i +: 16] = randOp();
            reqB[16*i +: 16] = randOp();
        end
        reqValid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("rotation", 32'(reqReady), 32'(4'b0001 << (n % 4)));
        end

        // Downstream stall for 5 cycles with traffic pending.
        @(posedge clk);
        #1 resReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_ready", 32'(reqReady), 0);
            check("stall_valid", 32'(resValid), 1);
        end
        @(posedge clk);
        #1 resReady = 1'b1;

        // Reset with products in flight, then lowest valid index wins.
        repeat (3) @(posedge clk);
        #1 resReady = 1'b0;
        repeat (2) @(posedge clk);
        pulseReset();
        reqValid = 4'b0110;
        resReady = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 32'(reqReady), 32'(4'b0010));
        check("post_rst_valid", 32'(resValid), 0);

        // Randomized traffic and backpressure, honoring the hold rule.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            acc = reqValid & reqReady;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (!reqValid[i] || acc[i]) begin
                    reqValid[i] = ($urandom_range(0, 2) != 0);
                    reqA[16*i +: 16] = randOp();
                    reqB[16*i +: 16] = randOp();
                end
            end
            resReady = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk);
        #1;
        reqValid = 4'b0000;
        resReady = 1'b1;
        for (int n = 0; n < 100 && sbQ.size() != 0; n++)
            @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(sbQ.size()), 0);
        check("drain_idle", 32'(resValid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
